// File: rtl/load_store_unit_if.sv
// load_store_unit_if: request/response handshake and word memory port of the load/store unit
interface load_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic [31:0] mem_rdata;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_addr, mem_wdata, mem_we
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_addr, mem_wdata, mem_we
    );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit: byte-lane loads/stores over a word-only memory, with read-modify-write and split spanning accesses
module load_store_unit (
    input  logic              clk,
    input  logic              rst,
    load_store_unit_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, RD0, RD1, WR0, WR1, RESP} state_t;

    state_t      state_q, state_d;
    logic        we_q, span_q, err_q;
    logic [2:0]  funct3_q, size_q;
    logic [1:0]  off_q;
    logic [29:0] w0_q, w1;
    logic [31:0] wdata_q, lo_q, hi_q;

    logic        accept, req_ok, req_span;
    logic [2:0]  req_size;
    logic [3:0]  ones;
    logic [7:0]  byte_mask;
    logic [63:0] bit_mask, data_w, buf_w, merged;
    logic [31:0] v, load_v;

    assign accept   = bus.req_valid && state_q == IDLE;
    assign req_ok   = bus.req_we ? bus.req_funct3 <= 3'd2 : bus.req_funct3 != 3'd3 && bus.req_funct3 < 3'd6;
    assign req_size = bus.req_funct3[1:0] == 2'd0 ? 3'd1 : bus.req_funct3[1:0] == 2'd1 ? 3'd2 : 3'd4;
    assign req_span = {1'b0, bus.req_addr[1:0]} + req_size > 3'd4;

    // Request latch, FSM state and read buffers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            we_q     <= 1'b0;
            span_q   <= 1'b0;
            err_q    <= 1'b0;
            funct3_q <= 3'd0;
            size_q   <= 3'd0;
            off_q    <= 2'd0;
            w0_q     <= 30'd0;
            wdata_q  <= 32'd0;
            lo_q     <= 32'd0;
            hi_q     <= 32'd0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                we_q     <= bus.req_we;
                span_q   <= req_span;
                err_q    <= !req_ok;
                funct3_q <= bus.req_funct3;
                size_q   <= req_size;
                off_q    <= bus.req_addr[1:0];
                w0_q     <= bus.req_addr[31:2];
                wdata_q  <= bus.req_wdata;
            end
            if (state_q == RD0) lo_q <= bus.mem_rdata;
            if (state_q == RD1) hi_q <= bus.mem_rdata;
        end
    end

    // Next-state sequencing of the word accesses
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = !req_ok ? RESP :
                                        (bus.req_we && bus.req_funct3 == 3'd2 && bus.req_addr[1:0] == 2'd0) ? WR0 : RD0;
            RD0:  state_d = span_q ? RD1 : we_q ? WR0 : RESP;
            RD1:  state_d = we_q ? WR0 : RESP;
            WR0:  state_d = span_q ? WR1 : RESP;
            WR1:  state_d = RESP;
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign w1        = w0_q + 30'd1;
    assign ones      = size_q == 3'd1 ? 4'b0001 : size_q == 3'd2 ? 4'b0011 : 4'b1111;
    assign byte_mask = {4'b0000, ones} << off_q;
    assign data_w    = {32'd0, wdata_q} << {off_q, 3'b000};
    assign buf_w     = {hi_q, lo_q};

    // Expand the byte-lane mask to a bit mask over the two-word window
    always_comb begin
        bit_mask = 64'd0;
        for (int i = 0; i < 8; i++) bit_mask[8*i +: 8] = {8{byte_mask[i]}};
    end

    assign merged = (buf_w & ~bit_mask) | (data_w & bit_mask);
    assign v      = 32'(buf_w >> {off_q, 3'b000});
    assign load_v = funct3_q == 3'd0 ? {{24{v[7]}}, v[7:0]} :
                    funct3_q == 3'd1 ? {{16{v[15]}}, v[15:0]} :
                    funct3_q == 3'd4 ? {24'd0, v[7:0]} :
                    funct3_q == 3'd5 ? {16'd0, v[15:0]} : v;

    assign bus.req_ready = state_q == IDLE;
    assign bus.rsp_valid = state_q == RESP;
    assign bus.rsp_err   = state_q == RESP && err_q;
    assign bus.rsp_rdata = (state_q == RESP && !we_q && !err_q) ? load_v : 32'd0;
    assign bus.mem_addr  = (state_q == RD0 || state_q == WR0) ? {w0_q, 2'b00} :
                           (state_q == RD1 || state_q == WR1) ? {w1, 2'b00} : 32'd0;
    assign bus.mem_we    = rst && (state_q == WR0 || state_q == WR1);
    assign bus.mem_wdata = state_q == WR0 ? merged[31:0] : state_q == WR1 ? merged[63:32] : 32'd0;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: table vectors, directed corner sequences and random traffic against a byte-level memory model
module tb_load_store_unit;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    load_store_unit_if bus ();
    load_store_unit dut (.clk(clk), .rst(rst), .bus(bus));

    logic [31:0] mem [16];
    logic [31:0] img [16];
    logic        init_en = 1'b0;

    assign bus.mem_rdata = mem[bus.mem_addr[5:2]];

    // Word memory: bulk image load or single-word commit on mem_we
    always @(posedge clk) begin
        if (init_en) mem <= img;
        else if (bus.mem_we) mem[bus.mem_addr[5:2]] <= bus.mem_wdata;
    end

    logic [7:0]  mb [64];
    int          total = 0;
    int          bad = 0;
    logic [31:0] got_rd;
    logic        got_err;
    int          got_lat, got_nwe;
    logic        cyc_we [16];
    logic        cyc_rdy [16];
    logic [31:0] cyc_addr [16];
    logic [31:0] cyc_wd [16];

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rd;
        logic        err;
        int          lat;
    } vec_t;
    vec_t tv [12];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] mword(input int i);
        return {mb[4*i+3], mb[4*i+2], mb[4*i+1], mb[4*i]};
    endfunction

    task automatic set_word(input int i, input logic [31:0] val);
        for (int b = 0; b < 4; b++) mb[4*i+b] = val[8*b +: 8];
    endtask

    task automatic reload();
        for (int i = 0; i < 16; i++) img[i] = mword(i);
        @(negedge clk) init_en = 1'b1;
        @(negedge clk) init_en = 1'b0;
    endtask

    function automatic int fsize(input logic [2:0] f3);
        return f3[1:0] == 2'd0 ? 1 : f3[1:0] == 2'd1 ? 2 : 4;
    endfunction

    function automatic bit fvalid(input logic we, input logic [2:0] f3);
        return we ? f3 <= 3'd2 : (f3 != 3'd3 && f3 < 3'd6);
    endfunction

    function automatic bit fspan(input logic [31:0] a, input logic [2:0] f3);
        return int'(a[1:0]) + fsize(f3) > 4;
    endfunction

    function automatic int elat(input logic we, input logic [2:0] f3, input logic [31:0] a);
        if (!fvalid(we, f3)) return 1;
        if (!we) return fspan(a, f3) ? 3 : 2;
        if (f3 == 3'd2 && a[1:0] == 2'd0) return 2;
        return fspan(a, f3) ? 5 : 3;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a);
        logic [31:0] r = 32'd0;
        logic [31:0] ba;
        for (int k = 0; k < fsize(f3); k++) begin
            ba = a + k;
            r[8*k +: 8] = mb[ba[5:0]];
        end
        if (f3 == 3'd0 && r[7]) r = r | 32'hFFFFFF00;
        if (f3 == 3'd1 && r[15]) r = r | 32'hFFFF0000;
        return r;
    endfunction

    task automatic ref_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        logic [31:0] ba;
        for (int k = 0; k < fsize(f3); k++) begin
            ba = a + k;
            mb[ba[5:0]] = wd[8*k +: 8];
        end
    endtask

    task automatic txn(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd, input bit hold);
        int w = 0;
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_we = we; bus.req_funct3 = f3; bus.req_addr = a; bus.req_wdata = wd;
        while (!bus.req_ready && w < 20) begin @(negedge clk); w++; end
        if (!bus.req_ready) chk("accept_timeout", {31'd0, bus.req_ready}, 32'd1);
        @(negedge clk);
        if (hold) begin
            bus.req_we = 1'b1; bus.req_funct3 = 3'd2; bus.req_addr = 32'h0; bus.req_wdata = 32'hDEADBEEF;
        end else bus.req_valid = 1'b0;
        got_lat = 0; got_nwe = 0; got_rd = 32'hX; got_err = 1'bX;
        for (int k = 0; k < 16; k++) begin cyc_we[k] = 1'b0; cyc_rdy[k] = 1'b0; cyc_addr[k] = 32'd0; cyc_wd[k] = 32'd0; end
        for (int k = 1; k < 12; k++) begin
            cyc_we[k] = bus.mem_we; cyc_rdy[k] = bus.req_ready; cyc_addr[k] = bus.mem_addr; cyc_wd[k] = bus.mem_wdata;
            if (bus.mem_we) got_nwe++;
            if (bus.rsp_valid) begin
                got_lat = k; got_rd = bus.rsp_rdata; got_err = bus.rsp_err;
                break;
            end
            @(negedge clk);
        end
        bus.req_valid = 1'b0;
        if (got_lat == 0) chk("rsp_timeout", 32'd0, 32'd1);
    endtask

    task automatic check_txn(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        bit ok = fvalid(we, f3);
        logic [31:0] act_w = 32'd0;
        logic [31:0] exp_w = 32'd0;
        bit found = 1'b0;
        txn(we, f3, a, wd, 1'b0);
        chk("rnd_rdata", got_rd, (ok && !we) ? ref_load(f3, a) : 32'd0);
        chk("rnd_err", {31'd0, got_err}, {31'd0, !ok});
        chk("rnd_lat", got_lat, elat(we, f3, a));
        chk("rnd_nwe", got_nwe, (ok && we) ? (fspan(a, f3) ? 2 : 1) : 0);
        if (ok && we) ref_store(f3, a, wd);
        for (int i = 0; i < 16; i++)
            if (!found && mem[i] !== mword(i)) begin found = 1'b1; act_w = mem[i]; exp_w = mword(i); end
        chk("rnd_mem", act_w, exp_w);
    endtask

    initial begin
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = 3'd0; bus.req_addr = 32'd0; bus.req_wdata = 32'd0;
        for (int i = 0; i < 64; i++) mb[i] = 8'h00;
        set_word(1, 32'h44332211);
        set_word(2, 32'hDDCCBBAA);
        reload();
        @(negedge clk);
        chk("rst_ready", {31'd0, bus.req_ready}, 32'd1);
        chk("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        chk("rst_rdata", bus.rsp_rdata, 32'd0);
        chk("rst_err", {31'd0, bus.rsp_err}, 32'd0);
        chk("rst_mem_we", {31'd0, bus.mem_we}, 32'd0);
        chk("rst_mem_addr", bus.mem_addr, 32'd0);
        chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", {31'd0, bus.req_ready}, 32'd1);

        tv[0]  = '{1'b0, 3'd0, 32'h7,        32'd0, 32'h00000044, 1'b0, 2};
        tv[1]  = '{1'b0, 3'd0, 32'hB,        32'd0, 32'hFFFFFFDD, 1'b0, 2};
        tv[2]  = '{1'b0, 3'd4, 32'hB,        32'd0, 32'h000000DD, 1'b0, 2};
        tv[3]  = '{1'b0, 3'd1, 32'h6,        32'd0, 32'h00004433, 1'b0, 2};
        tv[4]  = '{1'b0, 3'd2, 32'h6,        32'd0, 32'hBBAA4433, 1'b0, 3};
        tv[5]  = '{1'b0, 3'd1, 32'h7,        32'd0, 32'hFFFFAA44, 1'b0, 3};
        tv[6]  = '{1'b0, 3'd5, 32'h7,        32'd0, 32'h0000AA44, 1'b0, 3};
        tv[7]  = '{1'b0, 3'd3, 32'h4,        32'd0, 32'h00000000, 1'b1, 1};
        tv[8]  = '{1'b0, 3'd6, 32'h5,        32'd0, 32'h00000000, 1'b1, 1};
        tv[9]  = '{1'b1, 3'd4, 32'h4, 32'hCAFEF00D, 32'h00000000, 1'b1, 1};
        tv[10] = '{1'b0, 3'd2, 32'h4,        32'd0, 32'h44332211, 1'b0, 2};
        tv[11] = '{1'b0, 3'd0, 32'h4,        32'd0, 32'h00000011, 1'b0, 2};
        for (int i = 0; i < 12; i++) begin
            txn(tv[i].we, tv[i].f3, tv[i].addr, tv[i].wdata, 1'b0);
            chk($sformatf("vec%0d_rdata", i), got_rd, tv[i].rd);
            chk($sformatf("vec%0d_err", i), {31'd0, got_err}, {31'd0, tv[i].err});
            chk($sformatf("vec%0d_lat", i), got_lat, tv[i].lat);
            chk($sformatf("vec%0d_nwe", i), got_nwe, 0);
        end

        txn(1'b0, 3'd3, 32'h4, 32'd0, 1'b0);
        chk("inv_mem_addr", cyc_addr[1], 32'd0);
        chk("inv_mem_we", {31'd0, cyc_we[1]}, 32'd0);

        txn(1'b1, 3'd0, 32'h5, 32'hFFFFFFEE, 1'b0);
        chk("sb_lat", got_lat, 3);
        chk("sb_rd0_addr", cyc_addr[1], 32'h4);
        chk("sb_wr0_addr", cyc_addr[2], 32'h4);
        chk("sb_wr0_we", {31'd0, cyc_we[2]}, 32'd1);
        chk("sb_wr0_wdata", cyc_wd[2], 32'h4433EE11);
        chk("sb_nwe", got_nwe, 1);
        chk("sb_mem", mem[1], 32'h4433EE11);
        ref_store(3'd0, 32'h5, 32'hFFFFFFEE);
        txn(1'b0, 3'd2, 32'h4, 32'd0, 1'b0);
        chk("sb_readback", got_rd, 32'h4433EE11);

        set_word(1, 32'h44332211);
        reload();
        txn(1'b1, 3'd2, 32'h7, 32'h12345678, 1'b0);
        chk("sw_span_lat", got_lat, 5);
        chk("sw_span_we3", {31'd0, cyc_we[3]}, 32'd1);
        chk("sw_span_we4", {31'd0, cyc_we[4]}, 32'd1);
        chk("sw_span_addr3", cyc_addr[3], 32'h4);
        chk("sw_span_wd3", cyc_wd[3], 32'h78332211);
        chk("sw_span_addr4", cyc_addr[4], 32'h8);
        chk("sw_span_wd4", cyc_wd[4], 32'hDD123456);
        chk("sw_span_nwe", got_nwe, 2);
        chk("sw_span_mem1", mem[1], 32'h78332211);
        chk("sw_span_mem2", mem[2], 32'hDD123456);
        ref_store(3'd2, 32'h7, 32'h12345678);

        set_word(0, 32'h000000FF);
        set_word(15, 32'h80000000);
        reload();
        txn(1'b0, 3'd1, 32'hFFFFFFFF, 32'd0, 1'b0);
        chk("wrap_addr0", cyc_addr[1], 32'hFFFFFFFC);
        chk("wrap_addr1", cyc_addr[2], 32'h00000000);
        chk("wrap_lat", got_lat, 3);
        chk("wrap_rdata", got_rd, 32'hFFFFFF80);

        set_word(1, 32'h44332211);
        set_word(2, 32'hDDCCBBAA);
        reload();
        txn(1'b0, 3'd2, 32'h6, 32'd0, 1'b1);
        chk("busy_rdata", got_rd, 32'hBBAA4433);
        chk("busy_lat", got_lat, 3);
        chk("busy_ready1", {31'd0, cyc_rdy[1]}, 32'd0);
        chk("busy_ready2", {31'd0, cyc_rdy[2]}, 32'd0);
        chk("busy_nwe", got_nwe, 0);
        chk("busy_mem0", mem[0], 32'h000000FF);
        @(negedge clk);
        chk("busy_no_accept_ready", {31'd0, bus.req_ready}, 32'd1);
        chk("busy_no_accept_rsp", {31'd0, bus.rsp_valid}, 32'd0);

        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_funct3 = 3'd2; bus.req_addr = 32'h7; bus.req_wdata = 32'h12345678;
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rstmid_wr0_we", {31'd0, bus.mem_we}, 32'd1);
        @(negedge clk);
        chk("rstmid_wr1_we_before", {31'd0, bus.mem_we}, 32'd1);
        rst = 1'b0;
        #1;
        chk("rstmid_we_gated", {31'd0, bus.mem_we}, 32'd0);
        @(negedge clk);
        chk("rstmid_no_rsp", {31'd0, bus.rsp_valid}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("rstmid_ready", {31'd0, bus.req_ready}, 32'd1);
        chk("rstmid_no_rsp2", {31'd0, bus.rsp_valid}, 32'd0);
        chk("rstmid_mem1", mem[1], 32'h78332211);
        chk("rstmid_mem2", mem[2], 32'hDDCCBBAA);
        set_word(1, 32'h78332211);

        for (int n = 0; n < 150; n++) begin
            logic        we = 1'($urandom_range(0, 1));
            logic [2:0]  f3 = we ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 7));
            check_txn(we, f3, $urandom, $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=%0d want=finish", total);
        $fatal(1, "timeout");
    end
endmodule
